// File: rtl/dds_sweep_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_sweep_pkg : shared types and constants for the DDS sweep sequencer
// rev 1.0
// ---------------------------------------------------------------------------
package dds_sweep_pkg;

  localparam int PHI_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/dds_sweep_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_sweep_table : phase-increment table, one write port, async read
// rev 1.0
// ---------------------------------------------------------------------------
module dds_sweep_table
  import dds_sweep_pkg::*;
#(
  parameter int  N_POINTS = 16,
  localparam int IDX_W    = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [PHI_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [PHI_W-1:0] o_rdata
);

  logic [PHI_W-1:0] r_mem [N_POINTS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_sweep_ctrl : steps the DDS phase increment through a frequency table,
//                  settling and measuring over whole zero-crossing periods
// rev 1.0
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int  N_POINTS = 16,
  parameter int  PER_W    = 16,
  parameter int  TMO_W    = 24,
  localparam int IDX_W    = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic [PHI_W-1:0] tbl_data,
  input  logic [IDX_W:0]   n_points,
  input  logic [PER_W-1:0] settle_per,
  input  logic [PER_W-1:0] meas_per,
  input  logic [TMO_W-1:0] tmo_clks,
  input  logic             start,
  input  logic             abort,
  input  logic             pulso,
  output logic [PHI_W-1:0] phi_inc_o,
  output logic             dds_clken_o,
  output logic             meas_en_o,
  output logic [IDX_W-1:0] point_idx_o,
  output logic             point_done_o,
  output logic             sweep_done_o,
  output logic             busy_o,
  output logic             tmo_err_o
);

  localparam logic [IDX_W:0]   c_npts_max = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   c_npts_one = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] c_idx_one  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W:0]   c_per_one  = {{PER_W{1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] c_tmo_one  = {{(TMO_W-1){1'b0}}, 1'b1};

  sweep_state_t     r_state;
  logic [IDX_W:0]   r_npts;
  logic [PER_W-1:0] r_settle;
  logic [PER_W-1:0] r_meas;
  logic [IDX_W-1:0] r_idx;
  logic [PER_W:0]   r_per_cnt;
  logic [TMO_W-1:0] r_wdg;
  logic [PHI_W-1:0] r_phi;
  logic             r_meas_en;
  logic             r_point_done;
  logic             r_sweep_done;
  logic             r_busy;
  logic             r_tmo_err;

  logic [PHI_W-1:0] w_tbl_rd;
  logic             w_start_ok;
  logic [PER_W:0]   w_per_nxt;
  logic [PER_W:0]   w_meas_tgt;
  logic             w_settle_hit;
  logic             w_meas_hit;
  logic             w_last_pt;
  logic             w_wdg_act;
  logic [TMO_W-1:0] w_wdg_nxt;
  logic             w_wdg_trip;

  dds_sweep_table #(
    .N_POINTS (N_POINTS)
  ) u_table (
    .clk     (clk),
    .i_we    (tbl_we & ~r_busy),
    .i_waddr (tbl_addr),
    .i_wdata (tbl_data),
    .i_raddr (r_idx),
    .o_rdata (w_tbl_rd)
  );

  assign w_start_ok   = start && (n_points != '0) && (n_points <= c_npts_max);
  assign w_per_nxt    = r_per_cnt + c_per_one;
  // Settle needs settle_per+1 crossings so measurement always begins on one.
  assign w_settle_hit = (w_per_nxt == ({1'b0, r_settle} + c_per_one));
  assign w_meas_tgt   = (r_meas == '0) ? c_per_one : {1'b0, r_meas};
  assign w_meas_hit   = (w_per_nxt == w_meas_tgt);
  assign w_last_pt    = (({1'b0, r_idx} + c_npts_one) == r_npts);

  assign w_wdg_act    = ((r_state == SETTLE) || (r_state == MEASURE)) && (tmo_clks != '0);
  assign w_wdg_nxt    = r_wdg + c_tmo_one;
  assign w_wdg_trip   = w_wdg_act && !pulso && (w_wdg_nxt == tmo_clks);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_npts       <= '0;
      r_settle     <= '0;
      r_meas       <= '0;
      r_idx        <= '0;
      r_per_cnt    <= '0;
      r_wdg        <= '0;
      r_phi        <= '0;
      r_meas_en    <= 1'b0;
      r_point_done <= 1'b0;
      r_sweep_done <= 1'b0;
      r_busy       <= 1'b0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_point_done <= 1'b0;
      r_sweep_done <= 1'b0;
      r_wdg        <= (w_wdg_act && !pulso) ? w_wdg_nxt : '0;

      // Abort and watchdog expiry pre-empt every other transition; phi holds.
      if ((r_state != IDLE) && (abort || w_wdg_trip)) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_meas_en <= 1'b0;
        if (w_wdg_trip) begin
          r_tmo_err <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_ok && !abort) begin
              r_npts    <= n_points;
              r_settle  <= settle_per;
              r_meas    <= meas_per;
              r_idx     <= '0;
              r_tmo_err <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= LOAD;
            end
          end
          LOAD: begin
            r_phi     <= w_tbl_rd;
            r_per_cnt <= '0;
            r_state   <= SETTLE;
          end
          SETTLE: begin
            if (pulso) begin
              if (w_settle_hit) begin
                r_per_cnt <= '0;
                r_meas_en <= 1'b1;
                r_state   <= MEASURE;
              end else begin
                r_per_cnt <= w_per_nxt;
              end
            end
          end
          MEASURE: begin
            if (pulso) begin
              if (w_meas_hit) begin
                r_meas_en    <= 1'b0;
                r_point_done <= 1'b1;
                r_state      <= NEXT;
              end else begin
                r_per_cnt <= w_per_nxt;
              end
            end
          end
          NEXT: begin
            if (w_last_pt) begin
              r_sweep_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_idx   <= r_idx + c_idx_one;
              r_state <= LOAD;
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy    <= 1'b0;
            r_meas_en <= 1'b0;
            r_state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign phi_inc_o    = r_phi;
  assign dds_clken_o  = r_busy;
  assign meas_en_o    = r_meas_en;
  assign point_idx_o  = r_idx;
  assign point_done_o = r_point_done;
  assign sweep_done_o = r_sweep_done;
  assign busy_o       = r_busy;
  assign tmo_err_o    = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl : randomized sweeps checked against a timeline model
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  localparam int NP = 16;
  localparam int H  = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [4:0]  n_points;
  logic [15:0] settle_per;
  logic [15:0] meas_per;
  logic [23:0] tmo_clks;
  logic        start;
  logic        abort;
  logic        pulso;
  logic [31:0] phi_inc_o;
  logic        dds_clken_o;
  logic        meas_en_o;
  logic [3:0]  point_idx_o;
  logic        point_done_o;
  logic        sweep_done_o;
  logic        busy_o;
  logic        tmo_err_o;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .N_POINTS (NP),
    .PER_W    (16),
    .TMO_W    (24)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_data     (tbl_data),
    .n_points     (n_points),
    .settle_per   (settle_per),
    .meas_per     (meas_per),
    .tmo_clks     (tmo_clks),
    .start        (start),
    .abort        (abort),
    .pulso        (pulso),
    .phi_inc_o    (phi_inc_o),
    .dds_clken_o  (dds_clken_o),
    .meas_en_o    (meas_en_o),
    .point_idx_o  (point_idx_o),
    .point_done_o (point_done_o),
    .sweep_done_o (sweep_done_o),
    .busy_o       (busy_o),
    .tmo_err_o    (tmo_err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] tbl [NP];
  logic [31:0] phi_prev;
  logic [3:0]  idx_prev;
  bit          pul    [H];
  bit          e_busy [H];
  bit          e_meas [H];
  bit          e_pd   [H];
  bit          e_sd   [H];
  logic [31:0] e_phi  [H];
  logic [3:0]  e_idx  [H];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".clken"}, dds_clken_o, 0);
    chk({tag, ".meas_en"}, meas_en_o, 0);
    chk({tag, ".pdone"}, point_done_o, 0);
    chk({tag, ".sdone"}, sweep_done_o, 0);
    chk({tag, ".phi"}, phi_inc_o, 0);
    chk({tag, ".idx"}, point_idx_o, 0);
    chk({tag, ".tmo"}, tmo_err_o, 0);
  endtask

  // Cycle of the cnt-th crossing at or after cycle 'from' (H if none).
  function automatic int nth_pulse(input int from, input int cnt);
    int seen = 0;
    for (int c = from; c < H; c++) begin
      if (pul[c]) begin
        seen++;
        if (seen == cnt) return c;
      end
    end
    return H;
  endfunction

  // Expected output timeline for a sweep whose start is sampled at the end of cycle 0.
  task automatic build_model(input int n, input int st, input int ms, input int abt, output int last);
    int c, p, q, m;
    m = (ms == 0) ? 1 : ms;
    for (int i = 0; i < H; i++) begin
      e_busy[i] = 0; e_meas[i] = 0; e_pd[i] = 0; e_sd[i] = 0;
      e_phi[i] = phi_prev; e_idx[i] = idx_prev;
    end
    c = 1;
    for (int k = 0; k < n; k++) begin
      for (int i = c; i < H; i++) e_idx[i] = 4'(k);
      for (int i = c + 1; i < H; i++) e_phi[i] = tbl[k];
      p = nth_pulse(c + 1, st + 1);
      q = nth_pulse(p + 1, m);
      for (int i = p + 1; i <= q && i < H; i++) e_meas[i] = 1;
      if (q + 1 < H) e_pd[q + 1] = 1;
      c = q + 2;
    end
    if (c < H) e_sd[c] = 1;
    for (int i = 1; i <= c && i < H; i++) e_busy[i] = 1;
    last = c;
    if (abt >= 0 && abt < H && (abt == 0 || e_busy[abt])) begin
      for (int i = abt + 1; i < H; i++) begin
        e_busy[i] = 0; e_meas[i] = 0; e_pd[i] = 0; e_sd[i] = 0;
        e_phi[i] = e_phi[abt]; e_idx[i] = e_idx[abt];
      end
      last = abt;
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NP; i++) begin
      @(posedge clk); #1;
      tbl_we = 1'b1; tbl_addr = 4'(i); tbl_data = $urandom; tbl[i] = tbl_data;
    end
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  // abt_sel: -1 none, -2 random, -3 inside the measure window of point 1, >=0 fixed cycle
  task automatic run_trial(input int n, input int st, input int ms, input int abt_sel);
    int last, abt, endc, c0;
    for (int i = 0; i < H; i++) pul[i] = 1'b0;
    c0 = int'($urandom_range(1, 4));
    for (int i = c0; i < H; i = i + int'($urandom_range(2, 5))) pul[i] = 1'b1;
    build_model(n, st, ms, -1, last);
    abt = -1;
    if (abt_sel == -2) begin
      abt = int'($urandom_range(0, last));
    end else if (abt_sel == -3) begin
      for (int i = 0; i < H; i++) if (abt < 0 && e_meas[i] && e_idx[i] == 4'd1) abt = i + 1;
    end else if (abt_sel >= 0) begin
      abt = abt_sel;
    end
    if (abt >= 0) build_model(n, st, ms, abt, last);
    endc = (last + 3 < H) ? last + 3 : H - 1;
    n_points = 5'(n); settle_per = 16'(st); meas_per = 16'(ms);
    for (int c = 0; c <= endc; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) || (e_busy[c] && $urandom_range(0, 15) == 0);
      abort    = (c == abt);
      pulso    = pul[c];
      tbl_we   = e_busy[c] && ($urandom_range(0, 7) == 0);
      tbl_addr = 4'($urandom_range(0, 15));
      tbl_data = $urandom;
      @(negedge clk);
      chk($sformatf("busy@%0d", c), busy_o, e_busy[c]);
      chk($sformatf("clken@%0d", c), dds_clken_o, e_busy[c]);
      chk($sformatf("meas_en@%0d", c), meas_en_o, e_meas[c]);
      chk($sformatf("pdone@%0d", c), point_done_o, e_pd[c]);
      chk($sformatf("sdone@%0d", c), sweep_done_o, e_sd[c]);
      chk($sformatf("phi@%0d", c), phi_inc_o, e_phi[c]);
      chk($sformatf("idx@%0d", c), point_idx_o, e_idx[c]);
      chk($sformatf("tmo@%0d", c), tmo_err_o, 0);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; pulso = 1'b0; tbl_we = 1'b0;
    phi_prev = e_phi[endc];
    idx_prev = e_idx[endc];
  endtask

  initial begin
    reset_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    n_points = '0; settle_per = '0; meas_per = '0; tmo_clks = '0;
    start = 1'b0; abort = 1'b0; pulso = 1'b0;
    phi_prev = '0; idx_prev = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    load_table();
    run_trial(3, 2, 4, -1);
    load_table();
    run_trial(2, 0, 0, -1);
    load_table();
    run_trial(3, 1, 3, -3);
    run_trial(2, 1, 1, 0);
    for (int t = 0; t < 20; t++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 4));
      if (t % 4 == 0) load_table();
      run_trial(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) < 3) ? -2 : -1);
    end

    // Out-of-range point counts must not launch a sweep.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_points = (k == 0) ? 5'd0 : 5'd17;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk($sformatf("badn%0d.busy", k), busy_o, 0);
        chk($sformatf("badn%0d.idx", k), point_idx_o, idx_prev);
      end
    end

    // Watchdog: stalled DDS (phi=0), one crossing then silence.
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_data = 32'd0; tbl[0] = 32'd0;
    @(posedge clk); #1;
    tbl_we = 1'b0; tmo_clks = 24'd1000; n_points = 5'd1; settle_per = 16'd2; meas_per = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    pulso = 1'b1;
    @(posedge clk); #1;
    pulso = 1'b0;
    repeat (999) @(posedge clk);
    @(negedge clk);
    chk("wdg.pre.tmo", tmo_err_o, 0);
    chk("wdg.pre.busy", busy_o, 1);
    @(negedge clk);
    chk("wdg.tmo", tmo_err_o, 1);
    chk("wdg.busy", busy_o, 0);
    chk("wdg.meas_en", meas_en_o, 0);
    chk("wdg.phi", phi_inc_o, 0);
    @(posedge clk); #1;
    tmo_clks = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("wdg.clear.tmo", tmo_err_o, 0);
    chk("wdg.clear.busy", busy_o, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("wdg.abort.busy", busy_o, 0);

    // Asynchronous reset while settling.
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_data = 32'hA5A5_0001; tbl[0] = 32'hA5A5_0001;
    @(posedge clk); #1;
    tbl_we = 1'b0; n_points = 5'd2; settle_per = 16'd3; meas_per = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2.pre.busy", busy_o, 1);
    chk("rst2.pre.phi", phi_inc_o, 32'hA5A5_0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("rst2");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("rst2.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
